// File: rtl/mul_arbiter_2.sv
// mul_arbiter_2: round-robin front end sharing one 10x10 multiplier between two requesters.
// Optional WAIT-state watchdog is compiled in when MUL_ARB_TIMEOUT_EN is defined.
module mul_arbiter_2 #(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [9:0]  req0_a,
    input  logic [9:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [9:0]  req1_a,
    input  logic [9:0]  req1_b,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [19:0] resp0_data,
    output logic        resp0_err,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    output logic [19:0] resp1_data,
    output logic        resp1_err,
    input  logic        resp1_ready,
    output logic        mul_start,
    output logic [9:0]  mul_a,
    output logic [9:0]  mul_b,
    input  logic [19:0] mul_s,
    input  logic        mul_done
);

    // state | meaning
    // IDLE  | no operation; grants a pending request and latches its operands
    // START | mul_start asserted for START_CYCLES cycles
    // WAIT  | waiting for mul_done (or watchdog expiry when enabled)
    // RESP  | response held for the granted requester until it is consumed

    if (START_CYCLES < 1 || START_CYCLES > 15 || TIMEOUT < 1) begin : g_param_check
        $error("mul_arbiter_2: START_CYCLES must be 1..15 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        gnt_id;
    logic        prio;
    logic        gnt_nxt;
    logic        any_req;
    logic        resp_taken;
    logic [3:0]  start_cnt;
    logic [19:0] resp_data;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] to_cnt;
    logic          resp_err;
    logic          to_expired;

    assign to_expired = (to_cnt == '0);
`endif

    always_comb begin
        state_nxt  = state;
        any_req    = req0_valid | req1_valid;
        // prio names the requester that wins a tie; it flips to the other one after each grant
        gnt_nxt    = req1_valid & (~req0_valid | prio);
        resp_taken = gnt_id ? resp1_ready : resp0_ready;
        case (state)
            IDLE:  if (any_req) state_nxt = START;
            START: if (start_cnt == 4'd0) state_nxt = WAIT;
            WAIT: begin
                if (mul_done) state_nxt = RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                else if (to_expired) state_nxt = RESP;
`endif
            end
            RESP:  if (resp_taken) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req0_ready  = rst_n & (state == IDLE) & req0_valid & ~gnt_nxt;
    assign req1_ready  = rst_n & (state == IDLE) & gnt_nxt;
    assign mul_start   = (state == START);
    assign resp0_valid = (state == RESP) & ~gnt_id;
    assign resp1_valid = (state == RESP) & gnt_id;
    assign resp0_data  = resp_data;
    assign resp1_data  = resp_data;

`ifdef MUL_ARB_TIMEOUT_EN
    assign resp0_err = resp_err & ~gnt_id;
    assign resp1_err = resp_err & gnt_id;
`else
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_id    <= 1'b0;
            prio      <= 1'b0;
            start_cnt <= 4'd0;
            mul_a     <= 10'd0;
            mul_b     <= 10'd0;
            resp_data <= 20'd0;
`ifdef MUL_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            resp_err  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id    <= gnt_nxt;
                        prio      <= ~gnt_nxt;
                        mul_a     <= gnt_nxt ? req1_a : req0_a;
                        mul_b     <= gnt_nxt ? req1_b : req0_b;
                        start_cnt <= 4'(START_CYCLES - 1);
                    end
                end
                START: begin
                    if (start_cnt != 4'd0) start_cnt <= start_cnt - 4'd1;
`ifdef MUL_ARB_TIMEOUT_EN
                    to_cnt <= TW'(TIMEOUT - 1);
`endif
                end
                WAIT: begin
                    if (mul_done) begin
                        resp_data <= mul_s;
`ifdef MUL_ARB_TIMEOUT_EN
                        resp_err  <= 1'b0;
`endif
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    else if (to_expired) begin
                        resp_data <= 20'd0;
                        resp_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TW'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mul_arbiter_2.md
MUL_ARBITER_2 -- requirements
Module: mul_arbiter_2

Interface
REQ-001 SHALL have parameter START_CYCLES, default 2: number of cycles mul_start is held high per operation (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 64: cycles allowed in WAIT before an abort (used only when MUL_ARB_TIMEOUT_EN is defined).
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports: clk in 1, the clock, all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 reqN_valid  in  1, reqN_a  in  10, reqN_b  in  10 (N=0,1)  request handshake and operands.
REQ-006 reqN_ready  out  1  request accepted this cycle when high with reqN_valid.
REQ-007 respN_valid  out  1, respN_data  out  20, respN_err  out  1  response to requester N.
REQ-008 respN_ready  in  1  requester N consumes the response.
REQ-009 mul_start  out  1, mul_a  out  10, mul_b  out  10  drive the shared 10-bit multiplier.
REQ-010 mul_s  in  20, mul_done  in  1  multiplier product and completion flag.

Function
REQ-011 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-012 IDLE: if any reqN_valid, grant one, pulse reqN_ready for exactly one cycle, latch operands into mul_a/mul_b, latch grant id, go to START.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, requester 0 has priority.
REQ-014 START: mul_start high for exactly START_CYCLES cycles, then go to WAIT with mul_start low.
REQ-015 WAIT: on the first cycle with mul_done high, capture mul_s into the response register and go to RESP; mul_done seen during START SHALL be ignored.
REQ-016 RESP: respN_valid high for the granted N only, held with stable data until respN_ready high; that cycle returns to IDLE.
REQ-017 mul_a/mul_b SHALL remain stable from grant until leaving WAIT.
REQ-018 reqN_ready SHALL be low outside IDLE; a new request SHALL NOT be accepted in the same cycle a response is consumed (minimum one IDLE cycle).
REQ-019 respN_data SHALL be the full 20-bit unsigned product, no truncation.
REQ-020 respN_err SHALL be 0 on every normal completion.

Reset
REQ-021 While rst_n low: state IDLE, all ready/valid/err/mul_start low, mul_a/mul_b/respN_data zero, round-robin pointer to requester 0, timeout counter zero.
REQ-022 Reset asserted mid-operation SHALL abort immediately without emitting a response; the in-flight request is lost.
REQ-023 Deassertion SHALL resume in IDLE on the next rising edge.

Configuration
REQ-024 Macro MUL_ARB_TIMEOUT_EN defined: a counter runs in WAIT; if mul_done has not been seen after TIMEOUT cycles, enter RESP with respN_data=0 and respN_err=1 for the granted requester.
REQ-025 MUL_ARB_TIMEOUT_EN undefined: no counter, WAIT persists until mul_done, respN_err tied 0.

Verification
REQ-026 Single request: req0 a=10'd1023, b=10'd1023 -> mul_start high 2 cycles, resp0_valid with resp0_data=20'd1046529, resp0_err=0.
REQ-027 Simultaneous req0 (3x5) and req1 (7x9) after reset -> req0 served first (15), then req1 (63); resp1_valid never high during req0's response.
REQ-028 Back-pressure: resp1_ready held low 10 cycles -> resp1_valid and data stable for all 10, no new grant until consumed.
REQ-029 Both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-030 rst_n pulsed low during WAIT -> all outputs reset values at once, no response for the aborted request, next request completes correctly.
REQ-031 MUL_ARB_TIMEOUT_EN defined, mul_done held low -> after 64 WAIT cycles respN_valid=1, respN_err=1, respN_data=0; 1000 random operands against a behavioural model -> all products match.
